// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: N-lamp thermometer bar with a six-phase up/down sequence, built-in step prescaler and flick latch.
// Optional feature macro: BOUND_FLASHER_BLINK_EN adds the final all-on/all-off blink phase.
module bound_flasher_param #(
  parameter int unsigned N            = 16,
  parameter int unsigned B1           = 5,
  parameter int unsigned B2           = 10,
  parameter int unsigned DIV          = 25_000_000,
  parameter int unsigned BLINK_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flk,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam int unsigned LW = $clog2(N + 1);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] UP1   = 3'd1;
  localparam logic [2:0] DN1   = 3'd2;
  localparam logic [2:0] UP2   = 3'd3;
  localparam logic [2:0] DN2   = 3'd4;
  localparam logic [2:0] UP3   = 3'd5;
  localparam logic [2:0] DN3   = 3'd6;
`ifdef BOUND_FLASHER_BLINK_EN
  localparam logic [2:0] BLINK = 3'd7;
  localparam int unsigned BW   = $clog2(2 * BLINK_CYCLES + 1);
`endif

  // Reject impossible geometries at elaboration time.
  if (N < 4 || B1 == 0 || B1 >= B2 || B2 >= N - 1 || DIV < 1 || BLINK_CYCLES < 1) begin : g_param_err
    $error("bound_flasher_param: illegal parameter combination");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flk_pend_q, flk_pend_d;
  logic [2:0]    phase_q, phase_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [N-1:0]  out_q, out_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic          flk_eff;
`ifdef BOUND_FLASHER_BLINK_EN
  logic [BW-1:0] blink_q, blink_d;
`endif

  // Lamps 0..l-1 lit, the rest dark.
  function automatic logic [N-1:0] thermo(input logic [LW-1:0] l);
    logic [N-1:0] t;
    t = '0;
    for (int i = 0; i < int'(N); i++) t[i] = (LW'(i) < l);
    return t;
  endfunction

  // Prescaler, flick latch and phase sequencing; all state only moves on a tick.
  always_comb begin
    tick       = (cnt_q == CW'(DIV - 1));
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    flk_eff    = tick & (flk_pend_q | flk);
    flk_pend_d = tick ? 1'b0 : (flk_pend_q | flk);
    phase_d    = phase_q;
    lvl_d      = lvl_q;
    out_d      = out_q;
    busy_d     = busy_q;
`ifdef BOUND_FLASHER_BLINK_EN
    blink_d    = blink_q;
`endif

    if (tick) begin
      case (phase_q)
        IDLE: begin
          if (flk_eff) begin
            phase_d = UP1;
            lvl_d   = LW'(1);
          end
        end
        UP1: begin
          lvl_d = lvl_q + LW'(1);
          if (lvl_d == LW'(B1 + 1)) phase_d = DN1;
        end
        DN1: begin
          lvl_d = lvl_q - LW'(1);
          if (lvl_d == '0) phase_d = UP2;
        end
        UP2: begin
          lvl_d = lvl_q + LW'(1);
          if (lvl_d == LW'(B2 + 1))                  phase_d = flk_eff ? DN1 : DN2;
          else if (lvl_d == LW'(B1 + 1) && flk_eff)  phase_d = DN1;
        end
        DN2: begin
          lvl_d = lvl_q - LW'(1);
          if (lvl_d == LW'(B1)) phase_d = UP3;
        end
        UP3: begin
          lvl_d = lvl_q + LW'(1);
          if (lvl_d == LW'(N))                       phase_d = DN3;
          else if (lvl_d == LW'(B2 + 1) && flk_eff)  phase_d = DN2;
        end
        DN3: begin
          lvl_d = lvl_q - LW'(1);
`ifdef BOUND_FLASHER_BLINK_EN
          if (lvl_d == '0) phase_d = BLINK;
`else
          if (lvl_d == '0) phase_d = IDLE;
`endif
        end
`ifdef BOUND_FLASHER_BLINK_EN
        BLINK: begin
          blink_d = blink_q + BW'(1);
          if (blink_d == BW'(2 * BLINK_CYCLES)) begin
            phase_d = IDLE;
            blink_d = '0;
          end
        end
`endif
        default: begin
          phase_d = IDLE;
          lvl_d   = '0;
        end
      endcase

      busy_d = (phase_d != IDLE);
      out_d  = thermo(lvl_d);
`ifdef BOUND_FLASHER_BLINK_EN
      // Even blink ticks light every lamp, odd ones and the exit tick go dark.
      if (phase_q == BLINK) out_d = (phase_d == BLINK && !blink_q[0]) ? '1 : '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      flk_pend_q <= 1'b0;
      phase_q    <= IDLE;
      lvl_q      <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
`ifdef BOUND_FLASHER_BLINK_EN
      blink_q    <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      flk_pend_q <= flk_pend_d;
      phase_q    <= phase_d;
      lvl_q      <= lvl_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
`ifdef BOUND_FLASHER_BLINK_EN
      blink_q    <= blink_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Directed bench for bound_flasher_param: a DIV=1 instance for sequencing and a DIV=4 instance for the prescaler and flick latch.
module tb_bound_flasher_param;

`ifdef BOUND_FLASHER_BLINK_EN
  localparam int SEQ_TICKS = 58;
`else
  localparam int SEQ_TICKS = 56;
`endif

  logic        clk = 1'b0;
  logic        rst1 = 1'b1, flk1 = 1'b0;
  logic        rst4 = 1'b1, flk4 = 1'b0;
  logic [15:0] out1, out4;
  logic        busy1, busy4;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bound_flasher_param #(.N(16), .B1(5), .B2(10), .DIV(1), .BLINK_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1), .flk(flk1), .out(out1), .busy(busy1)
  );

  bound_flasher_param #(.N(16), .B1(5), .B2(10), .DIV(4), .BLINK_CYCLES(1)) u_dut4 (
    .clk(clk), .rst(rst4), .flk(flk4), .out(out4), .busy(busy4)
  );

  task automatic add_ramp(input int a, input int b);
    if (a <= b) for (int l = a; l <= b; l++) exp_q.push_back(16'((32'd1 << l) - 1));
    else        for (int l = a; l >= b; l--) exp_q.push_back(16'((32'd1 << l) - 1));
  endtask

  task automatic add_blink();
`ifdef BOUND_FLASHER_BLINK_EN
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
`endif
  endtask

  task automatic reset_dut1();
    rst1 = 1'b1;
    flk1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    flk1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL reset_out: got %h want 0000", out1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy1); end
    rst1 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out1 !== 16'h0000 || busy1 !== 1'b0) begin
        n_err++; $display("FAIL idle[%0d]: out=%h busy=%b want 0000/0", i, out1, busy1);
      end
    end
  endtask

  task automatic test_full_sequence();
    int busy_cnt;
    busy_cnt = 0;
    reset_dut1();
    exp_q.delete();
    add_ramp(1, 6); add_ramp(5, 0); add_ramp(1, 11); add_ramp(10, 5); add_ramp(6, 16); add_ramp(15, 0); add_blink();
    flk1 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      flk1 = 1'b0;
      if (busy1 === 1'b1) busy_cnt++;
      n_cmp++; if (out1 !== exp_q[i]) begin n_err++; $display("FAIL full_out[%0d]: got %h want %h", i, out1, exp_q[i]); end
      n_cmp++; if (busy1 !== (i != exp_q.size() - 1)) begin n_err++; $display("FAIL full_busy[%0d]: got %b", i, busy1); end
    end
    n_cmp++; if (busy_cnt != SEQ_TICKS - 1) begin n_err++; $display("FAIL full_len: busy ticks %0d want %0d", busy_cnt, SEQ_TICKS - 1); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out1 !== 16'h0000 || busy1 !== 1'b0) begin
        n_err++; $display("FAIL full_tail[%0d]: out=%h busy=%b want 0000/0", i, out1, busy1);
      end
    end
  endtask

  task automatic test_kickback_up2();
    reset_dut1();
    exp_q.delete();
    add_ramp(1, 6); add_ramp(5, 0);
    add_ramp(1, 6); add_ramp(5, 0); add_ramp(1, 6); add_ramp(5, 0);
    add_ramp(1, 11); add_ramp(10, 5); add_ramp(6, 16); add_ramp(15, 0); add_blink();
    flk1 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0)  flk1 = 1'b0;
      if (i == 11) flk1 = 1'b1;
      if (i == 35) flk1 = 1'b0;
      n_cmp++; if (out1 !== exp_q[i]) begin n_err++; $display("FAIL kick2_out[%0d]: got %h want %h", i, out1, exp_q[i]); end
      n_cmp++; if (busy1 !== (i != exp_q.size() - 1)) begin n_err++; $display("FAIL kick2_busy[%0d]: got %b", i, busy1); end
    end
  endtask

  task automatic test_kickback_up3();
    reset_dut1();
    exp_q.delete();
    add_ramp(1, 6); add_ramp(5, 0); add_ramp(1, 11); add_ramp(10, 5);
    add_ramp(6, 11); add_ramp(10, 5); add_ramp(6, 16); add_ramp(15, 0); add_blink();
    flk1 = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0)  flk1 = 1'b0;
      if (i == 33) flk1 = 1'b1;
      if (i == 34) flk1 = 1'b0;
      n_cmp++; if (out1 !== exp_q[i]) begin n_err++; $display("FAIL kick3_out[%0d]: got %h want %h", i, out1, exp_q[i]); end
      n_cmp++; if (busy1 !== (i != exp_q.size() - 1)) begin n_err++; $display("FAIL kick3_busy[%0d]: got %b", i, busy1); end
    end
  endtask

  task automatic test_mid_reset();
    reset_dut1();
    flk1 = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      flk1 = 1'b0;
    end
    n_cmp++; if (out1 !== 16'h01FF) begin n_err++; $display("FAIL mid_pre: got %h want 01ff", out1); end
    rst1 = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out1 !== 16'h0000) begin n_err++; $display("FAIL mid_rst_out: got %h want 0000", out1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy1); end
    rst1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out1 !== 16'h0000 || busy1 !== 1'b0) begin
        n_err++; $display("FAIL mid_idle[%0d]: out=%h busy=%b want 0000/0", i, out1, busy1);
      end
    end
  endtask

  task automatic test_latched_flick();
    rst4 = 1'b1;
    flk4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b0;
    @(posedge clk); #1;
    flk4 = 1'b1;
    @(posedge clk); #1;
    flk4 = 1'b0;
    n_cmp++; if (out4 !== 16'h0000 || busy4 !== 1'b0) begin n_err++; $display("FAIL latch_pre1: out=%h busy=%b want 0000/0", out4, busy4); end
    @(posedge clk); #1;
    n_cmp++; if (out4 !== 16'h0000 || busy4 !== 1'b0) begin n_err++; $display("FAIL latch_pre2: out=%h busy=%b want 0000/0", out4, busy4); end
    @(posedge clk); #1;
    n_cmp++; if (out4 !== 16'h0001) begin n_err++; $display("FAIL latch_tick_out: got %h want 0001", out4); end
    n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL latch_tick_busy: got %b want 1", busy4); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out4 !== 16'h0001) begin n_err++; $display("FAIL latch_hold[%0d]: got %h want 0001", i, out4); end
    end
    @(posedge clk); #1;
    n_cmp++; if (out4 !== 16'h0003) begin n_err++; $display("FAIL latch_step2: got %h want 0003", out4); end

    // A flick latched just before reset must not survive it.
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    flk4 = 1'b1;
    @(posedge clk); #1;
    flk4 = 1'b0;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out4 !== 16'h0000 || busy4 !== 1'b0) begin
        n_err++; $display("FAIL latch_lost[%0d]: out=%h busy=%b want 0000/0", i, out4, busy4);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_sequence();
    test_kickback_up2();
    test_kickback_up3();
    test_mid_reset();
    test_latched_flick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
